// File: rtl/gate_truth_sequencer.sv
// Steps a two-input gate through {x,y} = 00,01,10,11, samples z and grades the truth table.
// Optional glitch monitor enabled by defining SEQ_GLITCH_CHECK_EN; the measured table is on
// port meas_table because "table" is a reserved word in SystemVerilog.
module gate_truth_sequencer #(
   parameter int unsigned DWELL  = 10,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] expected,
   output logic       x,
   output logic       y,
   input  logic       z,
   output logic       busy,
   output logic       done,
   output logic [3:0] meas_table,
   output logic       pass,
   output logic [2:0] mismatch_cnt,
   output logic       glitch
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [7:0] SettleCnt = 8'(SETTLE);
   localparam logic [7:0] LastCnt   = 8'(DWELL - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] exp_q, exp_d;
   logic [3:0] tbl_q, tbl_d;
   logic       pass_q, pass_d;
   logic [2:0] mm_q, mm_d;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

`ifdef SEQ_GLITCH_CHECK_EN
   logic glitch_q, glitch_d;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      exp_d    = exp_q;
      tbl_d    = tbl_q;
      pass_d   = pass_q;
      mm_d     = mm_q;
`ifdef SEQ_GLITCH_CHECK_EN
      glitch_d = glitch_q;
`endif
      x        = 1'b0;
      y        = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               exp_d    = expected;
               tbl_d    = 4'b0000;
               pass_d   = 1'b0;
               mm_d     = 3'd0;
`ifdef SEQ_GLITCH_CHECK_EN
               glitch_d = 1'b0;
`endif
               idx_d    = 2'd0;
               cnt_d    = 8'd0;
               state_d  = StRun;
            end
         end

         StRun: begin
            busy   = 1'b1;
            {x, y} = idx_q;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == SettleCnt) begin
               tbl_d[idx_q] = z;
            end
`ifdef SEQ_GLITCH_CHECK_EN
            // After the sample point z must stay at the value just captured.
            if ((cnt_q > SettleCnt) && (z != tbl_q[idx_q])) begin
               glitch_d = 1'b1;
            end
`endif
            if (cnt_q == LastCnt) begin
               cnt_d = 8'd0;
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
               end else begin
                  // Grade from tbl_d so a sample taken on this same edge is included.
                  pass_d  = (tbl_d == exp_q);
                  mm_d    = popcount4(tbl_d ^ exp_q);
                  state_d = StDone;
               end
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= 2'd0;
         cnt_q    <= 8'd0;
         exp_q    <= 4'b0000;
         tbl_q    <= 4'b0000;
         pass_q   <= 1'b0;
         mm_q     <= 3'd0;
`ifdef SEQ_GLITCH_CHECK_EN
         glitch_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         exp_q    <= exp_d;
         tbl_q    <= tbl_d;
         pass_q   <= pass_d;
         mm_q     <= mm_d;
`ifdef SEQ_GLITCH_CHECK_EN
         glitch_q <= glitch_d;
`endif
      end
   end

   assign meas_table   = tbl_q;
   assign pass         = pass_q;
   assign mismatch_cnt = mm_q;
`ifdef SEQ_GLITCH_CHECK_EN
   assign glitch = glitch_q;
`else
   assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer with DWELL=4, SETTLE=1 and a modelled AND/XOR gate.
module tb_gate_truth_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] expected;
   logic       x, y, z;
   logic       busy, done, pass, glitch;
   logic [3:0] meas_table;
   logic [2:0] mismatch_cnt;

   logic xor_mode;
   logic force_one;

   int tests  = 0;
   int failed = 0;

`ifdef SEQ_GLITCH_CHECK_EN
   localparam logic GlitchExp = 1'b1;
`else
   localparam logic GlitchExp = 1'b0;
`endif

   gate_truth_sequencer #(
      .DWELL (4),
      .SETTLE(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .expected    (expected),
      .x           (x),
      .y           (y),
      .z           (z),
      .busy        (busy),
      .done        (done),
      .meas_table  (meas_table),
      .pass        (pass),
      .mismatch_cnt(mismatch_cnt),
      .glitch      (glitch)
   );

   always #5 clk = ~clk;

   always_comb begin
      z = force_one | (xor_mode ? (x ^ y) : (x & y));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      int pulses;
      int first_at;
      int second_at;

      rst       = 1'b1;
      start     = 1'b0;
      expected  = 4'b0000;
      xor_mode  = 1'b0;
      force_one = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_xy", {6'd0, x, y}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_table", {4'd0, meas_table}, 8'd0);
      check("rst_pass", {7'd0, pass}, 8'd0);
      check("rst_mm", {5'd0, mismatch_cnt}, 8'd0);
      check("rst_glitch", {7'd0, glitch}, 8'd0);
      rst = 1'b0;
      tick();

      // Test 1: AND gate, expected 1000; expected changed after start must not matter
      expected = 4'b1000;
      pulse_start();
      expected = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         check("t1_xy", {6'd0, x, y}, 8'(i / 4));
         check("t1_busy", {7'd0, busy}, 8'd1);
         check("t1_nodone", {7'd0, done}, 8'd0);
         tick();
      end
      check("t1_done", {7'd0, done}, 8'd1);
      check("t1_busy_lo", {7'd0, busy}, 8'd0);
      check("t1_xy_idle", {6'd0, x, y}, 8'd0);
      check("t1_table", {4'd0, meas_table}, 8'h08);
      check("t1_pass", {7'd0, pass}, 8'd1);
      check("t1_mm", {5'd0, mismatch_cnt}, 8'd0);
      check("t1_glitch", {7'd0, glitch}, 8'd0);
      tick();
      check("t1_done_1cyc", {7'd0, done}, 8'd0);
      check("t1_table_hold", {4'd0, meas_table}, 8'h08);
      check("t1_pass_hold", {7'd0, pass}, 8'd1);

      // Test 2: XOR gate against AND expectation
      xor_mode = 1'b1;
      expected = 4'b1000;
      pulse_start();
      wait_done(n);
      check("t2_latency", 8'(n), 8'd16);
      check("t2_table", {4'd0, meas_table}, 8'h06);
      check("t2_pass", {7'd0, pass}, 8'd0);
      check("t2_mm", {5'd0, mismatch_cnt}, 8'd3);
      tick();

      // Test 3: start re-pulsed 5 cycles into a run is ignored
      xor_mode = 1'b0;
      pulse_start();
      for (int i = 0; i < 4; i++) tick();
      pulse_start();
      wait_done(n);
      check("t3_latency", 8'(n), 8'd11);
      check("t3_pass", {7'd0, pass}, 8'd1);
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      check("t3_extra_done", 8'(pulses), 8'd0);

      // Test 4: reset during combination 10
      xor_mode = 1'b1;
      pulse_start();
      for (int i = 0; i < 9; i++) tick();
      check("t4_xy_pre", {6'd0, x, y}, 8'd2);
      check("t4_table_pre", {4'd0, meas_table}, 8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_xy", {6'd0, x, y}, 8'd0);
      check("t4_busy", {7'd0, busy}, 8'd0);
      check("t4_table", {4'd0, meas_table}, 8'd0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      check("t4_no_done", 8'(pulses), 8'd0);

      // Test 5: start held high for 40 cycles gives back-to-back runs
      xor_mode  = 1'b0;
      expected  = 4'b1000;
      start     = 1'b1;
      pulses    = 0;
      first_at  = 0;
      second_at = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) first_at = i;
            if (pulses == 2) second_at = i;
            check("t5_pass", {7'd0, pass}, 8'd1);
         end
      end
      start = 1'b0;
      check("t5_pulses", 8'(pulses), 8'd2);
      check("t5_first", 8'(first_at), 8'd17);
      check("t5_period", 8'(second_at - first_at), 8'd18);
      wait_done(n);
      check("t5_third_done", {7'd0, done}, 8'd1);
      tick();

      // Test 6: single-cycle z spike at cnt=3 of combination 00
      pulse_start();
      for (int i = 0; i < 3; i++) tick();
      force_one = 1'b1;
      tick();
      force_one = 1'b0;
      wait_done(n);
      check("t6_latency", 8'(n), 8'd12);
      check("t6_glitch", {7'd0, glitch}, {7'd0, GlitchExp});
      check("t6_table", {4'd0, meas_table}, 8'h08);
      check("t6_pass", {7'd0, pass}, 8'd1);
      tick();
      check("t6_glitch_hold", {7'd0, glitch}, {7'd0, GlitchExp});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
